// File: rtl/regfile_wport_arb.sv
// ---------------------------------------------------------------------------
// regfile_wport_arb
//
// Write-port arbiter for a 16-entry x 16-bit register file. Two requesters
// (A = pipeline writeback, B = memory-return path) each get a one-entry
// holding buffer. At most one buffer is granted per cycle and its contents
// become the registered write (wr_en / wr_reg / wr_data) on the next cycle.
// Writes to register 0 are accepted and granted but never reach the register
// file, because register 0 is hardwired to zero.
//
// Arbitration when both buffers are full:
//   default                          : round-robin, the requester not granted
//                                      last wins (A wins the first tie)
//   REGFILE_WPORT_ARB_FIXED_PRIO_EN  : A always wins, B can starve
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   a_valid/a_ready   requester A handshake; a_reg, a_data = write target/data
//   b_valid/b_ready   requester B handshake; b_reg, b_data = write target/data
//   wr_en/wr_reg/wr_data  registered register-file write port
//   busy              either holding buffer occupied
// ---------------------------------------------------------------------------
module regfile_wport_arb #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_reg,
  output logic [DW-1:0] wr_data,
  output logic          busy
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  logic          a_full_q, a_full_d;
  logic [AW-1:0] a_reg_q,  a_reg_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          b_full_q, b_full_d;
  logic [AW-1:0] b_reg_q,  b_reg_d;
  logic [DW-1:0] b_data_q, b_data_d;
  req_e          last_grant_q, last_grant_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_reg_q,  wr_reg_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic grant_a, grant_b;
  logic a_accept, b_accept;

  // Grant depends only on flops, so ready never has a path from valid.
  always_comb begin
`ifdef REGFILE_WPORT_ARB_FIXED_PRIO_EN
    grant_a = a_full_q;
`else
    grant_a = a_full_q && (!b_full_q || (last_grant_q == REQ_B));
`endif
    grant_b = b_full_q && !grant_a;
  end

  // A buffer being drained this cycle may be reloaded in the same cycle.
  assign a_ready  = !a_full_q || grant_a;
  assign b_ready  = !b_full_q || grant_b;
  assign a_accept = a_valid && a_ready;
  assign b_accept = b_valid && b_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves a signal unassigned and infers a latch.
    a_full_d     = a_full_q;
    a_reg_d      = a_reg_q;
    a_data_d     = a_data_q;
    b_full_d     = b_full_q;
    b_reg_d      = b_reg_q;
    b_data_d     = b_data_q;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;

    // Drain the granted buffer; a register-0 target is dropped silently.
    if (grant_a) begin
      a_full_d     = 1'b0;
      last_grant_d = REQ_A;
      if (a_reg_q != '0) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = a_reg_q;
        wr_data_d = a_data_q;
      end
    end else if (grant_b) begin
      b_full_d     = 1'b0;
      last_grant_d = REQ_B;
      if (b_reg_q != '0) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = b_reg_q;
        wr_data_d = b_data_q;
      end
    end

    // Loading after draining lets the reload win over the clear.
    if (a_accept) begin
      a_full_d = 1'b1;
      a_reg_d  = a_reg;
      a_data_d = a_data;
    end
    if (b_accept) begin
      b_full_d = 1'b1;
      b_reg_d  = b_reg;
      b_data_d = b_data;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_full_q     <= 1'b0;
      b_full_q     <= 1'b0;
      last_grant_q <= REQ_B;
      wr_en_q      <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      a_full_q     <= a_full_d;
      b_full_q     <= b_full_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // NOTE: buffer payload is left out of reset; it is only ever observed while
  // the matching full flag is set, so resetting it would add nothing.
  always_ff @(posedge clk) begin
    a_reg_q  <= a_reg_d;
    a_data_q <= a_data_d;
    b_reg_q  <= b_reg_d;
    b_data_q <= b_data_d;
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign busy    = a_full_q || b_full_q;

endmodule

// File: tb/tb_regfile_wport_arb.sv
// ---------------------------------------------------------------------------
// tb_regfile_wport_arb
//
// Self-checking bench for regfile_wport_arb. A behavioural model (two
// one-slot buffers and a turn pointer) predicts every output on every cycle;
// directed scenarios additionally pin the write stream to literal values.
// Build with +define+REGFILE_WPORT_ARB_FIXED_PRIO_EN to check fixed priority.
// ---------------------------------------------------------------------------
module tb_regfile_wport_arb;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic          busy;

  int total = 0;
  int bad   = 0;

  regfile_wport_arb #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_reg   (a_reg),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_reg   (b_reg),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = requester A, 1 = requester B.
  bit            m_on = 1'b0;
  bit            m_full [2];
  logic [AW-1:0] m_reg  [2];
  logic [DW-1:0] m_data [2];
  int            m_last;          // requester granted most recently
  logic          m_wr_en;
  logic [AW-1:0] m_wr_reg;
  logic [DW-1:0] m_wr_data;

  // Which buffer is served this cycle, or -1 if none.
  function automatic int pick();
    if (m_full[0] && m_full[1]) begin
`ifdef REGFILE_WPORT_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (m_last == 0) ? 1 : 0;
`endif
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic model_step();
    int  g;
    bit  take [2];
    if (rst) begin
      m_on      = 1'b1;
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_last    = 1;
      m_wr_en   = 1'b0;
      m_wr_reg  = '0;
      m_wr_data = '0;
      return;
    end
    if (!m_on) return;
    g = pick();
    take[0] = a_valid && (!m_full[0] || g == 0);
    take[1] = b_valid && (!m_full[1] || g == 1);
    m_wr_en = 1'b0;
    if (g >= 0) begin
      m_last = g;
      if (m_reg[g] != 0) begin
        m_wr_en   = 1'b1;
        m_wr_reg  = m_reg[g];
        m_wr_data = m_data[g];
      end
      m_full[g] = 1'b0;
    end
    if (take[0]) begin m_full[0] = 1'b1; m_reg[0] = a_reg; m_data[0] = a_data; end
    if (take[1]) begin m_full[1] = 1'b1; m_reg[1] = b_reg; m_data[1] = b_data; end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process + write log ----------------
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wlog [$];

  initial forever begin
    int g;
    @(negedge clk);
    if (m_on) begin
      g = pick();
      check("a_ready", a_ready, !m_full[0] || g == 0);
      check("b_ready", b_ready, !m_full[1] || g == 1);
      check("busy",    busy,    m_full[0] || m_full[1]);
      check("wr_en",   wr_en,   m_wr_en);
      check("wr_reg",  wr_reg,  m_wr_reg);
      check("wr_data", wr_data, m_wr_data);
      if (wr_en === 1'b1) wlog.push_back('{wr_reg, wr_data});
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wlog.delete();
  endtask

  task automatic check_log(input string name, input int idx, input logic [AW-1:0] r,
                           input logic [DW-1:0] d);
    if (wlog.size() <= idx) begin
      check({name, "_present"}, wlog.size(), idx + 1);
    end else begin
      check({name, "_reg"},  wlog[idx].r, r);
      check({name, "_data"}, wlog[idx].d, d);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    // Reset then idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      check("idle_wr_en",   wr_en,   1'b0);
      check("idle_wr_reg",  wr_reg,  '0);
      check("idle_wr_data", wr_data, '0);
      check("idle_ready",   {a_ready, b_ready}, 2'b11);
      check("idle_busy",    busy,    1'b0);
      step();
    end

    // Single write: handshake in t, buffer full t+1, write in t+2 only.
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'hBEEF;
    step();
    idle_inputs();
    check("single_t1_busy",  busy,  1'b1);
    check("single_t1_wr_en", wr_en, 1'b0);
    step();
    check("single_t2_wr_en",   wr_en,   1'b1);
    check("single_t2_wr_reg",  wr_reg,  4'd5);
    check("single_t2_wr_data", wr_data, 16'hBEEF);
    check("single_t2_busy",    busy,    1'b0);
    step();
    check("single_t3_wr_en",   wr_en,   1'b0);
    check("single_t3_wr_hold", wr_data, 16'hBEEF);

    // Tie right after reset: A first, then B.
    do_reset();
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_reg = 4'd2; b_data = 16'h2222;
    step();
    idle_inputs();
    repeat (4) step();
    check("tie_count", wlog.size(), 2);
    check_log("tie_first",  0, 4'd1, 16'h1111);
    check_log("tie_second", 1, 4'd2, 16'h2222);

    // Continuous contention, both to reg 3.
    wlog.delete();
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h3333;
    b_valid = 1'b1; b_reg = 4'd3; b_data = 16'h4444;
    repeat (8) step();
    idle_inputs();
    repeat (4) step();
`ifdef REGFILE_WPORT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) check_log("contend_fixed", i, 4'd3, 16'h3333);
`else
    for (int i = 0; i < 4; i++)
      check_log("contend_rr", i, 4'd3, (i % 2 == 0) ? 16'h3333 : 16'h4444);
`endif

    // Same destination from both requesters: later write wins.
    do_reset();
    a_valid = 1'b1; a_reg = 4'd7; a_data = 16'hAAAA;
    b_valid = 1'b1; b_reg = 4'd7; b_data = 16'hBBBB;
    step();
    idle_inputs();
    repeat (4) step();
    check("samedst_count", wlog.size(), 2);
    check_log("samedst_first", 0, 4'd7, 16'hAAAA);
    check_log("samedst_last",  1, 4'd7, 16'hBBBB);

    // Register-0 write is dropped, B stays usable.
    do_reset();
    b_valid = 1'b1; b_reg = 4'd0; b_data = 16'hFFFF;
    step();
    idle_inputs();
    repeat (4) step();
    check("r0_no_write", wlog.size(), 0);
    check("r0_b_ready",  b_ready,     1'b1);
    b_valid = 1'b1; b_reg = 4'd4; b_data = 16'h0004;
    step();
    idle_inputs();
    repeat (3) step();
    check("r0_after_count", wlog.size(), 1);
    check_log("r0_after", 0, 4'd4, 16'h0004);

    // Reset mid-operation discards both buffers and the pending write.
    do_reset();
    a_valid = 1'b1; a_reg = 4'd8; a_data = 16'h8888;
    b_valid = 1'b1; b_reg = 4'd9; b_data = 16'h9999;
    step();
    idle_inputs();
    check("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    check("midrst_no_write", wlog.size(), 0);
    check("midrst_busy",     busy,        1'b0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      a_valid = ($urandom_range(0, 9) < 7);
      b_valid = ($urandom_range(0, 9) < 7);
      a_reg   = AW'($urandom_range(0, 15));
      b_reg   = AW'($urandom_range(0, 15));
      a_data  = DW'($urandom);
      b_data  = DW'($urandom);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
